// File: rtl/vlsu_ar_mux.sv
// vlsu_ar_mux: round-robin AR arbiter with in-order R routing for the VLSU load engines.
// Optional full-stall performance counter enabled by VLSU_AR_MUX_PERF_EN.
module vlsu_ar_mux #(
  parameter int unsigned NrChannels     = 2,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NrChannels-1:0][AxiAddrWidth-1:0]   ch_ar_addr_i,
  input  logic [NrChannels-1:0][7:0]                ch_ar_len_i,
  input  logic [NrChannels-1:0][2:0]                ch_ar_size_i,
  input  logic [NrChannels-1:0]                     ch_ar_valid_i,
  output logic [NrChannels-1:0]                     ch_ar_ready_o,
  output logic [NrChannels-1:0][AxiDataWidth-1:0]   ch_r_data_o,
  output logic [NrChannels-1:0]                     ch_r_last_o,
  output logic [NrChannels-1:0]                     ch_r_valid_o,
  input  logic [NrChannels-1:0]                     ch_r_ready_i,
  output logic [AxiAddrWidth-1:0]                   ar_addr_o,
  output logic [7:0]                                ar_len_o,
  output logic [2:0]                                ar_size_o,
  output logic                                      ar_valid_o,
  input  logic                                      ar_ready_i,
  input  logic [AxiDataWidth-1:0]                   r_data_i,
  input  logic                                      r_last_i,
  input  logic                                      r_valid_i,
  output logic                                      r_ready_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]       outstanding_o,
`ifdef VLSU_AR_MUX_PERF_EN
  output logic                                      r_orphan_o,
  output logic [31:0]                               perf_full_stall_o
`else
  output logic                                      r_orphan_o
`endif
);
  localparam int unsigned IdxWidth = $clog2(NrChannels);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e                  r_state, w_state_nxt;
  logic [AxiAddrWidth-1:0] r_addr;
  logic [7:0]              r_len;
  logic [2:0]              r_size;
  logic [IdxWidth-1:0]     r_rr, w_win, w_c, w_head;
  logic [IdxWidth-1:0]     r_route [MaxOutstanding];
  logic [PtrWidth-1:0]     r_wr, r_rd;
  logic [CntWidth-1:0]     r_cnt;
  logic                    r_orphan, w_any, w_full, w_empty, w_load, w_pop;

  function automatic logic [PtrWidth-1:0] f_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full        = r_cnt == CntWidth'(MaxOutstanding);
  assign w_empty       = r_cnt == '0;
  assign w_head        = r_route[r_rd];
  assign w_pop         = r_valid_i && r_ready_o && r_last_i;
  assign ar_addr_o     = r_addr;
  assign ar_len_o      = r_len;
  assign ar_size_o     = r_size;
  assign ar_valid_o    = r_state == S_FULL;
  assign outstanding_o = r_cnt;
  assign r_orphan_o    = r_orphan;
  assign ch_r_data_o   = {NrChannels{r_data_i}};
  assign ch_r_last_o   = {NrChannels{r_last_i}};

  // Scan downwards so the channel closest after the last winner overrides the rest.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_c   = '0;
    for (int k = NrChannels - 1; k >= 0; k--) begin
      w_c = IdxWidth'((int'(r_rr) + k) % NrChannels);
      if (ch_ar_valid_i[w_c]) begin
        w_any = 1'b1;
        w_win = w_c;
      end
    end
  end

  always_comb begin
    w_load        = rst_ni && w_any && !w_full && (r_state == S_EMPTY || ar_ready_i);
    w_state_nxt   = w_load ? S_FULL : (ar_ready_i ? S_EMPTY : r_state);
    ch_ar_ready_o = '0;
    if (w_load) ch_ar_ready_o[w_win] = 1'b1;
    ch_r_valid_o  = '0;
    if (!w_empty) ch_r_valid_o[w_head] = r_valid_i;
    r_ready_o     = !w_empty && ch_r_ready_i[w_head];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_EMPTY;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_rr     <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_orphan <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_addr <= ch_ar_addr_i[w_win];
        r_len  <= ch_ar_len_i[w_win];
        r_size <= ch_ar_size_i[w_win];
        r_rr   <= (w_win == IdxWidth'(NrChannels - 1)) ? '0 : w_win + 1'b1;
        r_wr   <= f_inc(r_wr);
      end
      if (w_pop) r_rd <= f_inc(r_rd);
      r_cnt <= r_cnt + CntWidth'(w_load) - CntWidth'(w_pop);
      if (w_empty && r_valid_i) r_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_load) r_route[r_wr] <= w_win;
  end

`ifdef VLSU_AR_MUX_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) perf_full_stall_o <= '0;
    else if (|ch_ar_valid_i && w_full && perf_full_stall_o != '1) perf_full_stall_o <= perf_full_stall_o + 1'b1;
  end
`endif

endmodule
